// File: rtl/round_result_collector.sv
// Collects in-order rounds of four selector samples (select 0..3) into
// {sum, max, id} frames, buffered in a 2-entry FIFO with valid/ready drain.
module round_result_collector #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 10,
  parameter int DROP_W = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              EN,
  input  logic              CLR,
  input  logic [1:0]        select,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_max,
  output logic [3:0]        out_id,
  output logic              seq_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [0:0] WAIT0 = 1'b0;
  localparam logic [0:0] ACC   = 1'b1;

  logic [0:0]        r_state;
  logic [SUM_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_max;
  logic [1:0]        r_expect;
  logic [3:0]        r_id;
  logic              r_seq_err;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [1:0]        r_cnt;
  logic [SUM_W-1:0]  r_h_sum, r_t_sum;
  logic [DATA_W-1:0] r_h_max, r_t_max;
  logic [3:0]        r_h_id, r_t_id;

  logic [SUM_W-1:0]  w_data_ext;
  logic [SUM_W-1:0]  w_sum_next;
  logic [DATA_W-1:0] w_max_next;
  logic              w_in_order;
  logic              w_push;
  logic              w_pop;
  logic              w_full;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  assign w_data_ext = {{(SUM_W-DATA_W){1'b0}}, data};
  assign w_sum_next = r_acc + w_data_ext;
  assign w_max_next = (data > r_max) ? data : r_max;
  assign w_in_order = (r_state == ACC) && (select == r_expect);
  assign w_push     = EN && w_in_order && (r_expect == 2'd3);
  assign w_pop      = (r_cnt != 2'd0) && out_ready;
  assign w_full     = (r_cnt == 2'd2);

  // Round accumulation FSM
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= WAIT0;
      r_acc     <= '0;
      r_max     <= '0;
      r_expect  <= 2'd0;
      r_id      <= 4'd0;
      r_seq_err <= 1'b0;
    end else if (CLR) begin
      r_state   <= WAIT0;
      r_acc     <= '0;
      r_max     <= '0;
      r_expect  <= 2'd0;
      r_id      <= 4'd0;
      r_seq_err <= 1'b0;
    end else if (EN) begin
      if (w_in_order) begin
        if (r_expect == 2'd3) begin
          r_state  <= WAIT0;
          r_expect <= 2'd0;
          r_id     <= r_id + 4'd1;
        end else begin
          r_acc    <= w_sum_next;
          r_max    <= w_max_next;
          r_expect <= r_expect + 2'd1;
        end
      end else begin
        // Out-of-order in ACC discards the partial round; a select of 0 restarts it.
        if (r_state == ACC) r_seq_err <= 1'b1;
        if (select == 2'd0) begin
          r_state  <= ACC;
          r_acc    <= w_data_ext;
          r_max    <= data;
          r_expect <= 2'd1;
        end else begin
          r_state   <= WAIT0;
          r_expect  <= 2'd0;
          r_seq_err <= 1'b1;
        end
      end
    end
  end

  // Two-entry frame FIFO: head feeds the outputs directly, tail backs it up
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt      <= 2'd0;
      r_h_sum    <= '0;
      r_h_max    <= '0;
      r_h_id     <= 4'd0;
      r_t_sum    <= '0;
      r_t_max    <= '0;
      r_t_id     <= 4'd0;
      r_drop_cnt <= '0;
    end else if (CLR) begin
      r_cnt      <= 2'd0;
      r_h_sum    <= '0;
      r_h_max    <= '0;
      r_h_id     <= 4'd0;
      r_t_sum    <= '0;
      r_t_max    <= '0;
      r_t_id     <= 4'd0;
      r_drop_cnt <= '0;
    end else begin
      case (r_cnt)
        2'd0: if (w_push) begin
          r_h_sum <= w_sum_next;
          r_h_max <= w_max_next;
          r_h_id  <= r_id;
          r_cnt   <= 2'd1;
        end
        2'd1: if (w_push && w_pop) begin
          r_h_sum <= w_sum_next;
          r_h_max <= w_max_next;
          r_h_id  <= r_id;
        end else if (w_push) begin
          r_t_sum <= w_sum_next;
          r_t_max <= w_max_next;
          r_t_id  <= r_id;
          r_cnt   <= 2'd2;
        end else if (w_pop) begin
          r_cnt <= 2'd0;
        end
        default: if (w_pop) begin
          r_h_sum <= r_t_sum;
          r_h_max <= r_t_max;
          r_h_id  <= r_t_id;
          if (w_push) begin
            r_t_sum <= w_sum_next;
            r_t_max <= w_max_next;
            r_t_id  <= r_id;
          end else begin
            r_cnt <= 2'd1;
          end
        end else if (w_push && w_full) begin
          r_drop_cnt <= sat_inc(r_drop_cnt);
        end
      endcase
    end
  end

  assign out_valid = (r_cnt != 2'd0);
  assign out_sum   = r_h_sum;
  assign out_max   = r_h_max;
  assign out_id    = r_h_id;
  assign seq_err   = r_seq_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_round_result_collector.sv
// Randomized and directed bench for round_result_collector, checked against a
// queue-based model of rounds and buffered frames.
module tb_round_result_collector;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 10;
  localparam int DROP_W = 4;

  logic              clk = 1'b0;
  logic              Reset = 1'b0;
  logic              EN = 1'b0;
  logic              CLR = 1'b0;
  logic [1:0]        select = 2'd0;
  logic [DATA_W-1:0] data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic [3:0]        out_id;
  logic              seq_err;
  logic [DROP_W-1:0] drop_cnt;

  round_result_collector #(.DATA_W(DATA_W), .SUM_W(SUM_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .select(select), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_max(out_max), .out_id(out_id), .seq_err(seq_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int sum; int mx; int id;} frame_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     rnd[$];
  frame_t fq[$];
  int     m_id, m_drop;
  bit     m_seq, m_zero;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic void model_reset();
    rnd.delete(); fq.delete();
    m_id = 0; m_drop = 0; m_seq = 0; m_zero = 1;
  endfunction

  // One clock edge of the behavioural model, using the inputs seen at that edge.
  function automatic void model_edge(bit en, bit clr, int sel, int d, bit rdy);
    bit pop, full, done;
    int s, mx;
    if (clr) begin model_reset(); return; end
    pop = (fq.size() > 0) && rdy;
    full = (fq.size() == 2);
    done = 0;
    if (en) begin
      if (sel == rnd.size()) begin
        rnd.push_back(d);
        if (rnd.size() == 4) begin
          done = 1; s = 0; mx = 0;
          foreach (rnd[i]) begin s += rnd[i]; if (rnd[i] > mx) mx = rnd[i]; end
          rnd.delete();
        end
      end else begin
        m_seq = 1;
        rnd.delete();
        if (sel == 0) rnd.push_back(d);
      end
    end
    if (pop) void'(fq.pop_front());
    if (done) begin
      if (!full || pop) begin
        frame_t f;
        f.sum = s; f.mx = mx; f.id = m_id;
        fq.push_back(f);
        m_zero = 0;
      end else if (m_drop < (1 << DROP_W) - 1) begin
        m_drop++;
      end
      m_id = (m_id + 1) % 16;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, out_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      chk({tag, ".sum"}, out_sum, fq[0].sum);
      chk({tag, ".max"}, out_max, fq[0].mx);
      chk({tag, ".id"},  out_id,  fq[0].id);
    end else if (m_zero) begin
      chk({tag, ".sum0"}, out_sum, 0);
      chk({tag, ".max0"}, out_max, 0);
      chk({tag, ".id0"},  out_id,  0);
    end
    chk({tag, ".seq_err"},  seq_err,  m_seq);
    chk({tag, ".drop_cnt"}, drop_cnt, m_drop);
  endtask

  task automatic step(input string tag, input bit en, input bit clr, input int sel,
                      input int d, input bit rdy);
    EN = en; CLR = clr; select = 2'(sel); data = 8'(d); out_ready = rdy;
    @(posedge clk);
    model_edge(en, clr, sel, d, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    Reset = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk);
    Reset = 1'b1;
    EN = 1'b0; CLR = 1'b0;
  endtask

  // Four in-order samples; rdy_mask bit i drives out_ready on sample i.
  task automatic round(input string tag, input int d0, input int d1, input int d2,
                       input int d3, input logic [3:0] rdy_mask);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) step(tag, 1, 0, i, d[i], rdy_mask[i]);
  endtask

  initial begin
    int sel_ctr;
    model_reset();
    async_reset("rst");

    // Basic round
    round("t1", 1, 2, 3, 4, 4'hF);
    chk("t1.sum_c", out_sum, 10);
    chk("t1.max_c", out_max, 4);
    chk("t1.id_c", out_id, 0);
    step("t1.idle", 0, 0, 0, 0, 1);
    chk("t1.valid_c", out_valid, 0);

    // Max-valued rounds, id wrap
    for (int r = 0; r < 18; r++) round("t2", 255, 255, 255, 255, 4'hF);
    chk("t2.sum_c", out_sum, 'h3FC);

    // Back-pressure with one drop
    async_reset("t3.rst");
    for (int r = 0; r < 3; r++) round("t3", r + 1, 1, 1, 1, 4'h0);
    chk("t3.drop_c", drop_cnt, 1);
    chk("t3.id0_c", out_id, 0);
    step("t3.pop0", 0, 0, 0, 0, 1);
    chk("t3.id1_c", out_id, 1);
    step("t3.pop1", 0, 0, 0, 0, 1);
    chk("t3.empty_c", out_valid, 0);

    // Sequence error then a good round
    async_reset("t4.rst");
    step("t4", 1, 0, 0, 5, 0);
    step("t4", 1, 0, 1, 6, 0);
    step("t4", 1, 0, 3, 7, 0);
    chk("t4.seq_c", seq_err, 1);
    round("t4", 1, 1, 1, 1, 4'h0);
    chk("t4.sum_c", out_sum, 4);
    chk("t4.id_c", out_id, 0);

    // Full FIFO with a pop on the completing edge
    async_reset("t5.rst");
    round("t5", 1, 1, 1, 1, 4'h0);
    round("t5", 2, 2, 2, 2, 4'h0);
    round("t5", 3, 3, 3, 3, 4'h8);
    chk("t5.drop_c", drop_cnt, 0);
    chk("t5.id_c", out_id, 1);

    // Reset mid-round, then CLR with two frames queued
    step("t6", 1, 0, 0, 9, 0);
    step("t6", 1, 0, 1, 9, 0);
    async_reset("t6.rst");
    chk("t6.valid_c", out_valid, 0);
    round("t6", 1, 1, 1, 1, 4'h0);
    round("t6", 2, 2, 2, 2, 4'h0);
    step("t6.clr", 1, 1, 0, 0, 1);
    chk("t6.clr_valid_c", out_valid, 0);
    round("t6", 3, 4, 5, 6, 4'hF);
    chk("t6.id_c", out_id, 0);

    // Randomized traffic, mostly counter-driven selects
    sel_ctr = 0;
    for (int c = 0; c < 3000; c++) begin
      bit en, clr;
      int sel;
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 199) == 0);
      sel = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : sel_ctr;
      step("rand", en, clr, sel, int'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
      if (en) sel_ctr = (sel + 1) % 4;
      if (c == 1500) async_reset("rand.rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
